// File: rtl/seq_divider_if.sv
// seq_divider request/result bundle.
// Master drives the request, slave returns status and results.
interface seq_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic         signed_op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start,
        output signed_op,
        output dividend,
        output divisor,
        input  ready,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  overflow
    );

    modport slave (
        input  start,
        input  signed_op,
        input  dividend,
        input  divisor,
        output ready,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero,
        output overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// Signed mode divides magnitudes, then fixes signs in a final cycle.
module seq_divider #(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic [N-1:0] neg2(input logic [N-1:0] x);
        return ~x + ONE;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic           ovfp_q, ovfp_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remo_q, remo_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic           ready_w;
    logic           accept;
    logic           dvs_zero;
    logic           sgn;
    logic           dvd_neg;
    logic           dvs_neg;
    logic [N-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic [N:0]     rem_sh;
    logic [N:0]     diff;

    assign ready_w  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept   = ready_w && bus.start;
    assign dvs_zero = (bus.divisor == '0);

    // Operand conditioning: signs and magnitudes at the accept edge.
    assign sgn     = SIGNED_EN && bus.signed_op;
    assign dvd_neg = sgn && bus.dividend[N-1];
    assign dvs_neg = sgn && bus.divisor[N-1];
    assign dvd_mag = dvd_neg ? neg2(bus.dividend) : bus.dividend;
    assign dvs_mag = dvs_neg ? neg2(bus.divisor) : bus.divisor;

    // (N+1)-bit trial: shifted partial remainder minus divisor.
    assign rem_sh = {rem_q, dvd_q[N-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = dvs_zero ? S_DONE : S_CALC;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: capture, iterate, sign fix, result load.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        ovfp_d = ovfp_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        if (accept) begin
            cnt_d  = '0;
            rem_d  = '0;
            dvd_d  = dvd_mag;
            dvs_d  = dvs_mag;
            negq_d = dvd_neg ^ dvs_neg;
            negr_d = dvd_neg;
            ovfp_d = sgn && (bus.dividend == MOST_NEG) &&
                     (bus.divisor == '1);
            if (dvs_zero) begin
                quot_d = '1;
                remo_d = bus.dividend;
                dbz_d  = 1'b1;
                ovf_d  = 1'b0;
            end
        end else if (state_q == S_CALC) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (!diff[N]) begin
                rem_d = diff[N-1:0];
                dvd_d = {dvd_q[N-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[N-1:0];
                dvd_d = {dvd_q[N-2:0], 1'b0};
            end
        end else if (state_q == S_FIX) begin
            quot_d = negq_q ? neg2(dvd_q) : dvd_q;
            remo_d = negr_q ? neg2(rem_q) : rem_q;
            dbz_d  = 1'b0;
            ovf_d  = ovfp_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            ovfp_q <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            ovfp_q <= ovfp_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.ready       = ready_w;
    assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8, signed enabled).
// Vector table plus sequences for overlap, back-to-back and abort.
module tb_seq_divider;

    logic clk;
    logic rstn;

    seq_divider_if #(.N(8)) bus ();

    seq_divider #(
        .N(8),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sop;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
        int         bsy;
    } vec_t;

    vec_t vecs[13];
    int   tests;
    int   fails;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait for done with a cycle bound; lat counts edges from accept.
    task automatic wait_done(input string nm, inout int lat,
                             inout int bsy);
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bsy += int'(bus.busy);
        end
        chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    // Issue one request (caller is #1 after an edge with ready=1).
    task automatic do_op(input string nm, input bit sop,
                         input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bsy);
        bus.start     = 1'b1;
        bus.signed_op = sop;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.signed_op = ~sop;
        bus.dividend  = ~a;
        bus.divisor   = a;
        lat = 1;
        bsy = int'(bus.busy);
        wait_done(nm, lat, bsy);
    endtask

    initial begin
        int         lat;
        int         bsy;
        int         dn;
        string      nm;

        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0, 10, 9};
        vecs[1]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF, 1'b0, 1'b0, 10, 9};
        vecs[2]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01, 1'b0, 1'b0, 10, 9};
        vecs[3]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 1'b1, 10, 9};
        vecs[4]  = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80, 1'b0, 1'b0, 10, 9};
        vecs[5]  = '{1'b0, 8'd55,  8'd0,   8'hFF,  8'd55, 1'b1, 1'b0, 1,  0};
        vecs[6]  = '{1'b0, 8'hFF,  8'h01,  8'hFF,  8'h00, 1'b0, 1'b0, 10, 9};
        vecs[7]  = '{1'b0, 8'h05,  8'h09,  8'h00,  8'h05, 1'b0, 1'b0, 10, 9};
        vecs[8]  = '{1'b1, 8'hF9,  8'hFE,  8'h03,  8'hFF, 1'b0, 1'b0, 10, 9};
        vecs[9]  = '{1'b1, 8'h80,  8'h00,  8'hFF,  8'h80, 1'b1, 1'b0, 1,  0};
        vecs[10] = '{1'b0, 8'hFF,  8'hFF,  8'h01,  8'h00, 1'b0, 1'b0, 10, 9};
        vecs[11] = '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00, 1'b0, 1'b0, 10, 9};
        vecs[12] = '{1'b0, 8'd200, 8'd16,  8'd12,  8'd8,  1'b0, 1'b0, 10, 9};

        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #2;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            nm = $sformatf("v%0d", i);
            do_op(nm, vecs[i].sop, vecs[i].a, vecs[i].b, lat, bsy);
            chk({nm, "_q"}, 32'(bus.quotient), 32'(vecs[i].q));
            chk({nm, "_r"}, 32'(bus.remainder), 32'(vecs[i].r));
            chk({nm, "_dbz"}, 32'(bus.div_by_zero), 32'(vecs[i].dbz));
            chk({nm, "_ovf"}, 32'(bus.overflow), 32'(vecs[i].ovf));
            chk({nm, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            chk({nm, "_busy"}, 32'(bsy), 32'(vecs[i].bsy));
            chk({nm, "_ready"}, 32'(bus.ready), 32'd1);
        end

        // Results hold after the done pulse.
        @(posedge clk);
        #1;
        chk("hold_done", 32'(bus.done), 32'd0);
        chk("hold_ready", 32'(bus.ready), 32'd1);
        chk("hold_q", 32'(bus.quotient), 32'd12);
        chk("hold_r", 32'(bus.remainder), 32'd8);

        // start during CALC must be ignored.
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 8'd100;
        bus.divisor   = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        bsy = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        lat++;
        bus.start = 1'b0;
        wait_done("ign", lat, bsy);
        chk("ign_lat", 32'(lat), 32'd10);
        chk("ign_q", 32'(bus.quotient), 32'd14);
        chk("ign_r", 32'(bus.remainder), 32'd2);

        // start held through DONE: back-to-back second operation.
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 8'd100;
        bus.divisor   = 8'd7;
        @(posedge clk);
        #1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd16;
        lat = 1;
        bsy = 0;
        wait_done("b2b1", lat, bsy);
        chk("b2b1_lat", 32'(lat), 32'd10);
        chk("b2b1_q", 32'(bus.quotient), 32'd14);
        chk("b2b1_r", 32'(bus.remainder), 32'd2);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b2_busy", 32'(bus.busy), 32'd1);
        lat = 1;
        wait_done("b2b2", lat, bsy);
        chk("b2b2_lat", 32'(lat), 32'd10);
        chk("b2b2_q", 32'(bus.quotient), 32'd12);
        chk("b2b2_r", 32'(bus.remainder), 32'd8);

        // Reset in CALC cycle 4 aborts with no done pulse.
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 8'd100;
        bus.divisor   = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_q", 32'(bus.quotient), 32'd0);
        chk("abort_r", 32'(bus.remainder), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        dn = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            dn += int'(bus.done);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        do_op("post", 1'b0, 8'd200, 8'd16, lat, bsy);
        chk("post_q", 32'(bus.quotient), 32'd12);
        chk("post_r", 32'(bus.remainder), 32'd8);
        chk("post_lat", 32'(lat), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
